// File: rtl/matrix_store_allocator.sv
// Slot allocator and 256x8 backing store for generated matrices (SLOTS x 32-word windows).
// Define MAT_STORE_OVERWRITE_EN to recycle the oldest slot when the store is full.
module matrix_store_allocator #(
  parameter int SLOTS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dims_valid_i,
  input  logic [31:0] dim_m_i,
  input  logic [31:0] dim_n_i,
  output logic [7:0]  base_addr_o,
  output logic        addr_ready_o,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        done_i,
  input  logic        abort_i,
  input  logic [7:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  input  logic [2:0]  q_slot_i,
  output logic        q_valid_o,
  output logic [2:0]  q_m_o,
  output logic [2:0]  q_n_o,
  output logic [3:0]  count_o,
  output logic        full_o,
  output logic        alloc_fail_o,
  output logic        wr_err_o
);

`ifdef MAT_STORE_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif
  localparam logic [3:0] SLOTS_L = 4'(SLOTS);

  typedef enum logic [1:0] {IDLE, ALLOC, READY, FILL} state_t;
  state_t state, state_n;

  logic [2:0]       wr_ptr, wr_ptr_inc;
  logic [SLOTS-1:0] slot_valid;
  logic [2:0]       meta_m [SLOTS];
  logic [2:0]       meta_n [SLOTS];
  logic [2:0]       lat_m, lat_n;
  logic [7:0]       ram [256];
  logic             dims_ok, in_window, ram_we;
  logic             latch_dims, commit, take_slot, evict, fail_n;
  logic             unused_wr_data;

  assign unused_wr_data = ^wr_data_i[31:8];
  assign dims_ok    = (dim_m_i >= 32'd1) && (dim_m_i <= 32'd5) &&
                      (dim_n_i >= 32'd1) && (dim_n_i <= 32'd5);
  assign in_window  = (wr_addr_i[7:5] == wr_ptr);
  assign ram_we     = (state == FILL) && wr_en_i && in_window;
  assign wr_ptr_inc = ({1'b0, wr_ptr} == SLOTS_L - 4'd1) ? 3'd0 : wr_ptr + 3'd1;
  assign full_o     = (count_o == SLOTS_L);
  assign addr_ready_o = (state == READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    latch_dims = 1'b0;
    commit     = 1'b0;
    take_slot  = 1'b0;
    evict      = 1'b0;
    fail_n     = 1'b0;
    case (state)
      IDLE: begin
        if (dims_valid_i) begin
          if (dims_ok) begin
            latch_dims = 1'b1;
            state_n    = ALLOC;
          end else begin
            fail_n = 1'b1;
          end
        end
      end
      ALLOC: begin
        if (abort_i) begin
          state_n = IDLE;
        end else if (full_o && !OVERWRITE) begin
          fail_n  = 1'b1;
          state_n = IDLE;
        end else begin
          take_slot = 1'b1;
          evict     = full_o;
          state_n   = READY;
        end
      end
      READY: state_n = abort_i ? IDLE : FILL;
      FILL: begin
        if (abort_i) begin
          state_n = IDLE;
        end else if (dims_valid_i) begin
          // next matrix arriving implies the current one is finished
          commit = 1'b1;
          if (dims_ok) begin
            latch_dims = 1'b1;
            state_n    = ALLOC;
          end else begin
            fail_n  = 1'b1;
            state_n = IDLE;
          end
        end else if (done_i) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= 3'd0;
      slot_valid   <= '0;
      count_o      <= 4'd0;
      base_addr_o  <= 8'd0;
      lat_m        <= 3'd0;
      lat_n        <= 3'd0;
      alloc_fail_o <= 1'b0;
      wr_err_o     <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        meta_m[i] <= 3'd0;
        meta_n[i] <= 3'd0;
      end
    end else begin
      alloc_fail_o <= fail_n;
      wr_err_o     <= (state == FILL) && wr_en_i && !in_window;
      if (latch_dims) begin
        lat_m <= dim_m_i[2:0];
        lat_n <= dim_n_i[2:0];
      end
      if (take_slot) begin
        base_addr_o <= {wr_ptr, 5'd0};
        if (evict) begin
          slot_valid[wr_ptr] <= 1'b0;
          count_o            <= count_o - 4'd1;
        end
      end
      if (commit) begin
        slot_valid[wr_ptr] <= 1'b1;
        meta_m[wr_ptr]     <= lat_m;
        meta_n[wr_ptr]     <= lat_n;
        wr_ptr             <= wr_ptr_inc;
        count_o            <= count_o + 4'd1;
      end
    end
  end

  // RAM is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_addr_i] <= wr_data_i[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_o <= 8'd0;
      q_valid_o <= 1'b0;
      q_m_o     <= 3'd0;
      q_n_o     <= 3'd0;
    end else begin
      rd_data_o <= ram[rd_addr_i];
      if (({1'b0, q_slot_i} < SLOTS_L) && slot_valid[q_slot_i]) begin
        q_valid_o <= 1'b1;
        q_m_o     <= meta_m[q_slot_i];
        q_n_o     <= meta_n[q_slot_i];
      end else begin
        q_valid_o <= 1'b0;
        q_m_o     <= 3'd0;
        q_n_o     <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_store_allocator.sv
// Scoreboard bench for matrix_store_allocator: stimulus queues expectations, a negedge monitor checks them.
module tb_matrix_store_allocator;
  localparam int SLOTS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dims_valid_i = 1'b0;
  logic [31:0] dim_m_i = '0, dim_n_i = '0;
  logic [7:0]  base_addr_o;
  logic        addr_ready_o;
  logic        wr_en_i = 1'b0;
  logic [7:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        done_i = 1'b0, abort_i = 1'b0;
  logic [7:0]  rd_addr_i = '0;
  logic [7:0]  rd_data_o;
  logic [2:0]  q_slot_i = '0;
  logic        q_valid_o;
  logic [2:0]  q_m_o, q_n_o;
  logic [3:0]  count_o;
  logic        full_o, alloc_fail_o, wr_err_o;

  matrix_store_allocator #(.SLOTS(SLOTS)) dut (
    .clk(clk), .rst(rst), .dims_valid_i(dims_valid_i), .dim_m_i(dim_m_i), .dim_n_i(dim_n_i),
    .base_addr_o(base_addr_o), .addr_ready_o(addr_ready_o), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .done_i(done_i), .abort_i(abort_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .q_slot_i(q_slot_i), .q_valid_o(q_valid_o),
    .q_m_o(q_m_o), .q_n_o(q_n_o), .count_o(count_o), .full_o(full_o),
    .alloc_fail_o(alloc_fail_o), .wr_err_o(wr_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t chk_q[$];
  chk_t rdy_q[$];
  int   fail_q[$];
  int   err_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected pulse expected none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    chk_t c;
    int   d;
    if (addr_ready_o) begin
      if (rdy_q.size() == 0) unexpected("addr_ready");
      else begin
        c = rdy_q.pop_front();
        cmp("ready_cycle", cyc, c.due);
        cmp("ready_base", {24'd0, base_addr_o}, c.exp);
      end
    end
    if (alloc_fail_o) begin
      if (fail_q.size() == 0) unexpected("alloc_fail");
      else begin
        d = fail_q.pop_front();
        cmp("alloc_fail_cycle", cyc, d);
      end
    end
    if (wr_err_o) begin
      if (err_q.size() == 0) unexpected("wr_err");
      else begin
        d = err_q.pop_front();
        cmp("wr_err_cycle", cyc, d);
      end
    end
    while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
      c = chk_q.pop_front();
      case (c.kind)
        0: cmp(c.name, {24'd0, rd_data_o}, c.exp);
        1: cmp(c.name, {25'd0, q_valid_o, q_m_o, q_n_o}, c.exp);
        2: cmp(c.name, {28'd0, count_o}, c.exp);
        3: cmp(c.name, {31'd0, full_o}, c.exp);
        default: cmp(c.name, {24'd0, base_addr_o}, c.exp);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input int due, input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.due = due; c.kind = kind; c.exp = exp; c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic req(input int m, input int n);
    dims_valid_i = 1'b1; dim_m_i = m; dim_n_i = n;
    tick();
    dims_valid_i = 1'b0;
  endtask

  task automatic push_ready(input int due, input int base);
    chk_t c;
    c.due = due; c.kind = 4; c.exp = base; c.name = "ready";
    rdy_q.push_back(c);
  endtask

  // request, then advance until the DUT is in FILL
  task automatic start(input int m, input int n, input int base);
    push_ready(cyc + 2, base);
    req(m, n);
    tick();
    tick();
  endtask

  // dims_valid held through ALLOC and READY must not re-trigger allocation
  task automatic start_hold(input int m, input int n, input int base);
    push_ready(cyc + 2, base);
    dims_valid_i = 1'b1; dim_m_i = m; dim_n_i = n;
    tick(); tick(); tick();
    dims_valid_i = 1'b0;
  endtask

  task automatic bad_req(input int m, input int n, input int lat);
    fail_q.push_back(cyc + lat);
    req(m, n);
    tick();
  endtask

  task automatic wr(input int a, input int d, input bit err);
    if (err) err_q.push_back(cyc + 1);
    wr_en_i = 1'b1; wr_addr_i = 8'(a); wr_data_i = {24'hABCDEF, 8'(d)};
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic rd(input int a, input int exp);
    rd_addr_i = 8'(a);
    push_chk(cyc + 1, 0, exp, "rd_data");
    tick();
  endtask

  task automatic qry(input int slot, input bit v, input int m, input int n);
    logic [6:0] e;
    e = {v, 3'(m), 3'(n)};
    q_slot_i = 3'(slot);
    push_chk(cyc + 1, 1, {25'd0, e}, "query");
    tick();
  endtask

  task automatic cnt(input int c);
    push_chk(cyc, 2, c, "count");
    push_chk(cyc, 3, (c == SLOTS) ? 1 : 0, "full");
  endtask

  task automatic pulse_done();
    done_i = 1'b1; tick(); done_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    cnt(0);
    push_chk(cyc, 4, 0, "reset_base");
    push_chk(cyc, 0, 0, "reset_rd_data");
    push_chk(cyc, 1, 0, "reset_query");
    tick();
    rst = 1'b0;
    tick();

    // slot 0: 2x3, six writes, commit
    start(2, 3, 0);
    for (int i = 0; i < 6; i++) wr(i, 8'hA0 + i, 1'b0);
    pulse_done();
    cnt(1);
    qry(0, 1'b1, 2, 3);
    rd(0, 8'hA0);
    rd(5, 8'hA5);

    // dimension range boundaries
    bad_req(6, 2, 1);
    bad_req(0, 3, 1);
    bad_req(3, 6, 1);
    cnt(1);

    // slot 1: window checks, read-during-write, write with done
    start(5, 5, 32);
    wr(70, 8'h99, 1'b1);
    wr(31, 8'h98, 1'b1);
    wr(64, 8'h97, 1'b1);
    wr(33, 7, 1'b0);
    wr(63, 8'h3F, 1'b0);
    rd(33, 7);
    rd(63, 8'h3F);
    wr(34, 8'h22, 1'b0);
    rd_addr_i = 8'd34;
    push_chk(cyc + 1, 0, 8'h22, "rd_old_data");
    wr(34, 8'h33, 1'b0);
    rd(34, 8'h33);
    wr_en_i = 1'b1; wr_addr_i = 8'd40; wr_data_i = 32'h0000005A; done_i = 1'b1;
    tick();
    wr_en_i = 1'b0; done_i = 1'b0;
    cnt(2);
    rd(40, 8'h5A);
    qry(1, 1'b1, 5, 5);

    // slot 2: abort discards, retry reuses base 64
    start(1, 1, 64);
    wr(70, 8'h44, 1'b0);
    pulse_abort();
    cnt(2);
    qry(2, 1'b0, 0, 0);
    start(3, 4, 64);
    pulse_done();
    cnt(3);
    qry(2, 1'b1, 3, 4);

    // slot 3: abort beats a simultaneous done
    start(2, 2, 96);
    abort_i = 1'b1; done_i = 1'b1;
    tick();
    abort_i = 1'b0; done_i = 1'b0;
    cnt(3);
    qry(3, 1'b0, 0, 0);

    // slot 3 again, out-of-window write leaves RAM[70] intact, then gen-flow hand-off
    start(2, 2, 96);
    wr(70, 8'h55, 1'b1);
    rd(70, 8'h44);
    start(4, 1, 128);
    cnt(4);
    qry(3, 1'b1, 2, 2);
    pulse_done();
    cnt(5);

    start_hold(1, 5, 160);
    pulse_done();
    start(5, 1, 192);
    pulse_done();
    start(3, 3, 224);
    pulse_done();
    cnt(8);
    qry(7, 1'b1, 3, 3);

`ifdef MAT_STORE_OVERWRITE_EN
    start(4, 4, 0);
    cnt(7);
    qry(0, 1'b0, 0, 0);
    pulse_done();
    cnt(8);
    qry(0, 1'b1, 4, 4);
`else
    bad_req(4, 4, 2);
    cnt(8);
    qry(0, 1'b1, 2, 3);
`endif

    repeat (4) tick();
    cmp("pending_ready", rdy_q.size(), 0);
    cmp("pending_fail", fail_q.size(), 0);
    cmp("pending_err", err_q.size(), 0);
    cmp("pending_checks", chk_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_store_allocator.md
MATRIX_STORE_ALLOCATOR -- requirements
Module: matrix_store_allocator

Interface
REQ-001 SHALL have parameter SLOTS, default 8, meaning number of matrix slots (fixed 32 words each, base = slot*32).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port dims_valid_i  in  1  allocation request from input stage.
REQ-005 SHALL have port dim_m_i, dim_n_i  in  32 each  requested rows/cols.
REQ-006 SHALL have port base_addr_o  out  8  base address of current slot.
REQ-007 SHALL have port addr_ready_o  out  1  one-cycle pulse; base_addr_o valid.
REQ-008 SHALL have port wr_en_i, wr_addr_i, wr_data_i  in  1/8/32  element write (absolute address).
REQ-009 SHALL have port done_i  in  1  commit pulse (input stage finished).
REQ-010 SHALL have port abort_i  in  1  discard uncommitted slot (input disabled).
REQ-011 SHALL have port rd_addr_i  in  8; rd_data_o  out  8  storage read.
REQ-012 SHALL have port q_slot_i  in  3; q_valid_o  out  1; q_m_o, q_n_o  out  3 each  slot metadata query.
REQ-013 SHALL have port count_o  out  4  committed slots; full_o  out  1  count_o==SLOTS.
REQ-014 SHALL have port alloc_fail_o, wr_err_o  out  1 each  one-cycle error pulses.

Function
REQ-015 SHALL implement FSM states IDLE, ALLOC, READY, FILL.
REQ-016 IDLE: on dims_valid_i with both dims in 1..5 -> latch dims, go ALLOC; dims outside 1..5 -> pulse alloc_fail_o, stay IDLE.
REQ-017 ALLOC: slot = wr_ptr; if full and overwrite disabled -> pulse alloc_fail_o, go IDLE; else set base_addr_o = slot*32, go READY.
REQ-018 READY: assert addr_ready_o for exactly this one cycle, go FILL; latency dims_valid_i to addr_ready_o = 2 cycles.
REQ-019 dims_valid_i SHALL be ignored in ALLOC and READY.
REQ-020 FILL: wr_en_i with base <= wr_addr_i < base+32 writes wr_data_i[7:0] into 256x8 RAM; out-of-window write dropped, wr_err_o pulsed.
REQ-021 FILL: done_i -> commit (slot valid=1, store m/n, wr_ptr=(wr_ptr+1) mod SLOTS, count_o+1), go IDLE.
REQ-022 FILL: dims_valid_i (next generated matrix) -> commit current slot and allocate next, i.e. behave as IDLE request same cycle (go ALLOC).
REQ-023 abort_i in any non-IDLE state -> slot stays invalid, wr_ptr unchanged, go IDLE; abort_i wins over done_i/dims_valid_i same cycle.
REQ-024 wr_en_i and done_i same cycle: write performed, then commit.
REQ-025 rd_data_o SHALL equal RAM[rd_addr_i] one cycle after presentation; write-then-read same address same cycle returns old data.
REQ-026 q_valid_o/q_m_o/q_n_o SHALL be registered, one-cycle latency from q_slot_i; q_slot_i >= SLOTS returns q_valid_o=0.
REQ-027 wr_ptr SHALL wrap SLOTS-1 -> 0.

Reset
REQ-028 rst SHALL force IDLE, wr_ptr=0, all slot valid=0, count_o=0, full_o=0, base_addr_o=0, all pulses 0, rd_data_o=0, q_* = 0.
REQ-029 RAM contents SHALL NOT be cleared by reset; reset mid-FILL discards the slot.

Configuration
REQ-030 Macro MAT_STORE_OVERWRITE_EN defined: when full, ALLOC reuses slot wr_ptr (oldest), clears its valid, decrements count_o, proceeds to READY.
REQ-031 Macro undefined: allocation when full SHALL pulse alloc_fail_o and never assert addr_ready_o.

Verification
REQ-032 dims_valid_i with m=2,n=3 in IDLE at cycle t -> addr_ready_o at t+2, base_addr_o=0; 6 writes 0..5, done_i -> count_o=1, q_slot 0 gives valid=1,m=2,n=3.
REQ-033 m=6,n=2 -> alloc_fail_o pulse, no addr_ready_o, count_o unchanged.
REQ-034 In FILL slot 1 (base 32), write wr_addr_i=70 -> wr_err_o pulse, RAM[70] unchanged; write addr 33 data 7 -> rd_addr_i=33 returns 7 next cycle.
REQ-035 abort_i during FILL of slot 2 -> q_valid for slot 2 =0, next allocation again gets base 64.
REQ-036 Fill 8 slots, request 9th: macro undefined -> alloc_fail_o, full_o=1; macro defined -> base_addr_o=0, slot 0 invalidated, count_o=7 until commit returns it to 8.
REQ-037 Gen flow: dims_valid_i asserted in FILL of slot 0 -> slot 0 committed and addr_ready_o 2 cycles later with base_addr_o=32.
